// File: rtl/switch_out_arbiter_if.sv
// Handshake bundle between the four switch inputs, one output arbiter and
// its output port. The slave view belongs to the arbiter, the master view to
// whatever drives the inputs and sinks the output.
`timescale 1ns/1ps
interface switch_out_arbiter_if;
  logic [3:0]  in_valid;
  logic [63:0] in_data;
  logic [3:0]  in_suspend;
  logic        out_valid;
  logic [15:0] out_data;
  logic [1:0]  out_src;
  logic        out_suspend;

  modport slave (
    input  in_valid, in_data, out_suspend,
    output in_suspend, out_valid, out_data, out_src
  );

  modport master (
    output in_valid, in_data, out_suspend,
    input  in_suspend, out_valid, out_data, out_src
  );
endinterface

// File: rtl/switch_out_arbiter.sv
// Output-port scheduler for the 4-port packet switch.
// Buffers one packet per input whose target bit matches PORT_ID, picks the
// next one round-robin and emits it as a one-cycle strobe, followed by an
// enforced idle gap so that packets leave at most once per 1+IDLE_GAP cycles.
// Optional feature macro: SWITCH_ARB_STATS_EN (per-input grant counters).
`timescale 1ns/1ps
module switch_out_arbiter #(
  parameter int PORT_ID  = 0,
  parameter int IDLE_GAP = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  switch_out_arbiter_if.slave    sw,
  input  logic [1:0]             stat_sel,
  input  logic                   stat_clr,
  output logic [15:0]            stat_count
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  // The IDLE cycle in which the next grant is decided is itself an output
  // idle cycle, so the GAP state only needs to cover IDLE_GAP-1 cycles.
  localparam logic [3:0] GAP_LOAD = (IDLE_GAP > 1) ? 4'(IDLE_GAP - 1) : 4'd1;

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic [1:0]  out_src_q, out_src_d;

  logic [3:0]  buf_vld_q, buf_vld_d;
  logic [15:0] buf_data_q [4];
  logic [15:0] buf_data_d [4];

  logic [3:0]  capture;
  logic [3:0]  grant_vec;
  logic        grant;
  logic [1:0]  win;

  genvar gi;

  // Per-input holding buffer: capture only a matching word into an empty slot;
  // a slot is never captured and granted in the same cycle.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_in
      assign capture[gi]    = sw.in_valid[gi] & ~buf_vld_q[gi]
                            & sw.in_data[16*gi + PORT_ID];
      assign buf_vld_d[gi]  = capture[gi] | (buf_vld_q[gi] & ~grant_vec[gi]);
      assign buf_data_d[gi] = capture[gi] ? sw.in_data[16*gi +: 16] : buf_data_q[gi];
    end
  endgenerate

  // Buffer storage; reset drops every held packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_vld_q <= 4'b0;
      for (int i = 0; i < 4; i++) buf_data_q[i] <= 16'h0;
    end else begin
      buf_vld_q <= buf_vld_d;
      for (int i = 0; i < 4; i++) buf_data_q[i] <= buf_data_d[i];
    end
  end

  assign sw.in_suspend = buf_vld_q;

  // Round-robin pick: first occupied buffer at rr_ptr, rr_ptr+1, ... (mod 4).
  always_comb begin
    win = rr_ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (buf_vld_q[2'(rr_ptr_q + 2'(k))]) win = 2'(rr_ptr_q + 2'(k));
    end
  end

  assign grant_vec = grant ? (4'b0001 << win) : 4'b0000;

  // Next-state and output logic of the scheduler.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gap_cnt_d   = gap_cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    grant       = 1'b0;
    case (state_q)
      IDLE: begin
        if ((|buf_vld_q) && !sw.out_suspend) begin
          grant       = 1'b1;
          out_valid_d = 1'b1;
          out_data_d  = buf_data_q[win];
          out_src_d   = win;
          rr_ptr_d    = 2'(win + 2'd1);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (IDLE_GAP < 2) begin
          state_d = IDLE;
        end else begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - 4'd1;
        if (gap_cnt_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Scheduler state and registered output port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      gap_cnt_q   <= 4'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0;
      out_src_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gap_cnt_q   <= gap_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign sw.out_valid = out_valid_q;
  assign sw.out_data  = out_data_q;
  assign sw.out_src   = out_src_q;

`ifdef SWITCH_ARB_STATS_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];

  // Saturating grant counters; a clear overrides a same-cycle grant.
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      assign cnt_d[gi] = stat_clr ? 16'h0 :
                         (grant_vec[gi] && cnt_q[gi] != 16'hFFFF) ? cnt_q[gi] + 16'd1 :
                         cnt_q[gi];
    end
  endgenerate

  // Counter storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 16'h0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign stat_count = cnt_q[stat_sel];
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_count  = 16'h0;
`endif

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Randomised and directed bench for switch_out_arbiter (PORT_ID=2, IDLE_GAP=2)
// against a transaction-level model: buffers as a bit set, arbitration as a
// round-robin search and the output pacing as a minimum distance between
// grant cycles.
`timescale 1ns/1ps
module tb_switch_out_arbiter;
  localparam int PORT_ID  = 2;
  localparam int IDLE_GAP = 2;
  localparam int PERIOD   = (IDLE_GAP + 1 < 2) ? 2 : IDLE_GAP + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  stat_sel;
  logic        stat_clr;
  logic [15:0] stat_count;

  switch_out_arbiter_if sw();

  switch_out_arbiter #(.PORT_ID(PORT_ID), .IDLE_GAP(IDLE_GAP)) dut (
    .clk        (clk),
    .reset      (reset),
    .sw         (sw),
    .stat_sel   (stat_sel),
    .stat_clr   (stat_clr),
    .stat_count (stat_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  bit [3:0]    m_buf;
  logic [15:0] m_word [4];
  int          m_rr;
  int          m_last;
  int          m_cnt [4];
  bit          m_out_valid;
  logic [15:0] m_out_data;
  int          m_out_src;
  int          cyc = 0;

  // observation counters for directed scenarios
  int valid_cnt;
  int susp_cnt [4];
  int src_log [$];
  int cyc_log [$];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mk(input logic [7:0] data, input logic [3:0] src, input logic [3:0] tgt);
    return {data, src, tgt};
  endfunction

  task automatic model_reset();
    m_buf       = 4'b0;
    m_rr        = 0;
    m_last      = -100;
    m_out_valid = 1'b0;
    m_out_data  = 16'h0;
    m_out_src   = 0;
    for (int i = 0; i < 4; i++) begin
      m_word[i] = 16'h0;
      m_cnt[i]  = 0;
    end
  endtask

  task automatic model_edge(input logic [3:0] v, input logic [63:0] d, input logic sus, input logic clr);
    bit [3:0] old;
    bit [3:0] nxt;
    int win;
    old = m_buf;
    nxt = m_buf;
    m_out_valid = 1'b0;
    if (old != 4'b0 && !sus && (cyc - m_last) >= PERIOD) begin
      win = -1;
      for (int k = 0; k < 4; k++) begin
        if (win < 0 && old[(m_rr + k) % 4]) win = (m_rr + k) % 4;
      end
      m_out_valid = 1'b1;
      m_out_data  = m_word[win];
      m_out_src   = win;
      m_rr        = (win + 1) % 4;
      m_last      = cyc;
      nxt[win]    = 1'b0;
      if (m_cnt[win] < 65535) m_cnt[win]++;
    end
    if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    for (int i = 0; i < 4; i++) begin
      if (!old[i] && v[i] && d[16*i + PORT_ID]) begin
        nxt[i]    = 1'b1;
        m_word[i] = d[16*i +: 16];
      end
    end
    m_buf = nxt;
  endtask

  function automatic logic [15:0] exp_stat(input logic [1:0] sel);
`ifdef SWITCH_ARB_STATS_EN
    return 16'(m_cnt[sel]);
`else
    return 16'h0;
`endif
  endfunction

  task automatic step(input logic [3:0] v, input logic [63:0] d, input logic sus,
                      input logic [1:0] sel, input logic clr);
    sw.in_valid    = v;
    sw.in_data     = d;
    sw.out_suspend = sus;
    stat_sel       = sel;
    stat_clr       = clr;
    @(posedge clk);
    cyc++;
    model_edge(v, d, sus, clr);
    #1;
    check_value("out_valid",  32'(sw.out_valid),  32'(m_out_valid));
    check_value("out_data",   32'(sw.out_data),   32'(m_out_data));
    check_value("out_src",    32'(sw.out_src),    32'(m_out_src));
    check_value("in_suspend", 32'(sw.in_suspend), 32'(m_buf));
    check_value("stat_count", 32'(stat_count),    32'(exp_stat(sel)));
    if (sw.out_valid) begin
      valid_cnt++;
      src_log.push_back(int'(sw.out_src));
      cyc_log.push_back(cyc);
      $display("cycle %0d: packet src=%0d data=%h", cyc, sw.out_src, sw.out_data);
    end
    for (int i = 0; i < 4; i++) if (sw.in_suspend[i]) susp_cnt[i]++;
  endtask

  task automatic idle(input int n, input logic sus);
    for (int i = 0; i < n; i++) step(4'b0, 64'h0, sus, 2'd0, 1'b0);
  endtask

  task automatic clear_obs();
    valid_cnt = 0;
    for (int i = 0; i < 4; i++) susp_cnt[i] = 0;
    src_log.delete();
    cyc_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sw.in_valid    = 4'b0;
    sw.in_data     = 64'h0;
    sw.out_suspend = 1'b0;
    stat_sel       = 2'd0;
    stat_clr       = 1'b0;
    #1;
    check_value("rst_out_valid",  32'(sw.out_valid),  32'h0);
    check_value("rst_out_data",   32'(sw.out_data),   32'h0);
    check_value("rst_out_src",    32'(sw.out_src),    32'h0);
    check_value("rst_in_suspend", 32'(sw.in_suspend), 32'h0);
    check_value("rst_stat_count", 32'(stat_count),    32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] d;
    logic [3:0]  v;
    model_reset();
    clear_obs();
    do_reset();

    // single packet from input 0
    clear_obs();
    d = {48'h0, mk(8'hA5, 4'h1, 4'b0100)};
    step(4'b0001, d, 1'b0, 2'd0, 1'b0);
    idle(6, 1'b0);
    check_value("A_valid_count", 32'(valid_cnt), 32'd1);
    check_value("A_susp0_cycles", 32'(susp_cnt[0]), 32'd1);
    if (src_log.size() > 0) check_value("A_src", 32'(src_log[0]), 32'd0);

    // all four inputs at once, broadcast, from a fresh round-robin pointer
    do_reset();
    clear_obs();
    d = {mk(8'h13, 4'h3, 4'hF), mk(8'h12, 4'h2, 4'hF), mk(8'h11, 4'h1, 4'hF), mk(8'h10, 4'h0, 4'hF)};
    step(4'b1111, d, 1'b0, 2'd0, 1'b0);
    idle(14, 1'b0);
    check_value("B_valid_count", 32'(valid_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < src_log.size()) check_value("B_src_order", 32'(src_log[i]), 32'(i));
      if (i > 0 && i < cyc_log.size())
        check_value("B_strobe_spacing", 32'(cyc_log[i] - cyc_log[i-1]), 32'(1 + IDLE_GAP));
    end

    // downstream suspend holds a buffered packet from input 1
    clear_obs();
    d = {32'h0, mk(8'h77, 4'h1, 4'b0100), 16'h0};
    step(4'b0010, d, 1'b1, 2'd0, 1'b0);
    idle(10, 1'b1);
    check_value("C_no_valid", 32'(valid_cnt), 32'd0);
    check_value("C_susp1_cycles", 32'(susp_cnt[1]), 32'd11);
    idle(1, 1'b0);
    check_value("C_release", 32'(sw.out_valid), 32'd1);
    idle(4, 1'b0);

    // packet not addressed to this port
    clear_obs();
    d = {mk(8'h55, 4'h3, 4'b0001), 48'h0};
    step(4'b1000, d, 1'b0, 2'd0, 1'b0);
    idle(4, 1'b0);
    check_value("D_no_valid", 32'(valid_cnt), 32'd0);
    check_value("D_no_susp", 32'(susp_cnt[3]), 32'd0);

    // reset during GAP with three buffers still full
    d = {mk(8'hD3, 4'h3, 4'hF), mk(8'hD2, 4'h2, 4'hF), mk(8'hD1, 4'h1, 4'hF), mk(8'hD0, 4'h0, 4'hF)};
    step(4'b1111, d, 1'b0, 2'd0, 1'b0);
    idle(2, 1'b0);
    check_value("E_three_full", 32'($countones(sw.in_suspend)), 32'd3);
    do_reset();
    clear_obs();
    idle(10, 1'b0);
    check_value("E_no_stale", 32'(valid_cnt), 32'd0);

    // grant statistics for input 2
    for (int n = 0; n < 5; n++) begin
      d = {16'h0, mk(8'(8'h20 + n), 4'h2, 4'b0100), 32'h0};
      step(4'b0100, d, 1'b0, 2'd2, 1'b0);
      idle(3, 1'b0);
    end
    step(4'b0, 64'h0, 1'b0, 2'd2, 1'b0);
`ifdef SWITCH_ARB_STATS_EN
    check_value("F_count5", 32'(stat_count), 32'd5);
`else
    check_value("F_count5", 32'(stat_count), 32'd0);
`endif
    step(4'b0, 64'h0, 1'b0, 2'd2, 1'b1);
    step(4'b0, 64'h0, 1'b0, 2'd2, 1'b0);
    check_value("F_cleared", 32'(stat_count), 32'd0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      v = 4'b0;
      for (int i = 0; i < 4; i++) v[i] = ($urandom_range(99) < 35);
      d = {$urandom, $urandom};
      step(v, d, ($urandom_range(99) < 20), 2'($urandom_range(3)), ($urandom_range(99) < 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
